sobel_edge_filter: RTL and testbench

// 3x3 Sobel gradient stage directly downstream of the 3-line BRAM line buffer.

---
 rtl/sobel_edge_filter_if.sv | 22 ++
 rtl/sobel_edge_filter.sv | 164 ++++++++++++++++
 tb/tb_sobel_edge_filter.sv | 377 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sobel_edge_filter_if.sv
// rtl/sobel_edge_filter_if.sv - column-in / tagged-pixel-out bundle for the Sobel stage
interface sobel_edge_filter_if;
    logic [2:0][6:0] line_buffer_in;
    logic [10:0]     hcount_in;
    logic [9:0]      vcount_in;
    logic            data_valid_in;
    logic [6:0]      pixel_out;
    logic            edge_out;
    logic [10:0]     hcount_out;
    logic [9:0]      vcount_out;
    logic            data_valid_out;

    modport master (
        output line_buffer_in, hcount_in, vcount_in, data_valid_in,
        input  pixel_out, edge_out, hcount_out, vcount_out, data_valid_out
    );

    modport slave (
        input  line_buffer_in, hcount_in, vcount_in, data_valid_in,
        output pixel_out, edge_out, hcount_out, vcount_out, data_valid_out
    );
endinterface

// File: rtl/sobel_edge_filter.sv
// rtl/sobel_edge_filter.sv - 3x3 Sobel magnitude with edge threshold, retagged to the centre pixel
module sobel_edge_filter #(
    parameter int H_ACTIVE  = 320,
    parameter int V_ACTIVE  = 240,
    parameter int MAG_SHIFT = 3,
    parameter int THRESHOLD = 32
) (
    input  logic               clk_in,
    input  logic               rst_in,
    sobel_edge_filter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

    localparam logic [10:0] H_LAST = 11'(H_ACTIVE - 1);
    localparam logic [9:0]  V_LAST = 10'(V_ACTIVE - 1);
    localparam logic [7:0]  THR    = 8'(THRESHOLD);

    state_t state_q, state_d;
    logic   row_start, accept, flush, emit;

    assign row_start = bus.data_valid_in && (bus.hcount_in == 11'd0);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (row_start) begin
            state_d = FILL;
        end else begin
            case (state_q)
                IDLE:      state_d = IDLE;
                FILL, RUN: if (bus.data_valid_in)
                               state_d = (bus.hcount_in == H_LAST) ? FLUSH : RUN;
                FLUSH:     state_d = IDLE;
                default:   state_d = IDLE;
            endcase
        end
    end

    // A row-start beat landing on the FLUSH cycle shares the shift: the flush still emits.
    always_comb begin
        flush  = (state_q == FLUSH);
        accept = row_start || (bus.data_valid_in && (state_q == FILL || state_q == RUN));
        emit   = flush || (accept && !row_start);
    end

    logic [2:0][6:0] col_l_q, col_c_q, col_r_q;
    logic [10:0]     hc_c_q, hc_r_q;
    logic [9:0]      vc_c_q, vc_r_q;
    logic            v0_q;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            col_l_q <= '0;
            col_c_q <= '0;
            col_r_q <= '0;
            hc_c_q  <= '0;
            hc_r_q  <= '0;
            vc_c_q  <= '0;
            vc_r_q  <= '0;
            v0_q    <= 1'b0;
        end else begin
            v0_q <= emit;
            if (accept || flush) begin
                col_l_q <= col_c_q;
                col_c_q <= col_r_q;
                hc_c_q  <= hc_r_q;
                vc_c_q  <= vc_r_q;
                col_r_q <= accept ? bus.line_buffer_in : '0;
                hc_r_q  <= accept ? bus.hcount_in : '0;
                vc_r_q  <= accept ? bus.vcount_in : '0;
            end
        end
    end

    function automatic logic signed [10:0] px(input logic [6:0] p);
        return $signed({4'd0, p});
    endfunction

    logic signed [10:0] gx_d, gy_d, gx_q, gy_q;
    logic               border_d, border_q;
    logic [10:0]        hc1_q;
    logic [9:0]         vc1_q;
    logic               v1_q;

    // Column index [2] is the top row, [0] the bottom row.
    always_comb begin
        gx_d = (px(col_r_q[2]) + (px(col_r_q[1]) <<< 1) + px(col_r_q[0]))
             - (px(col_l_q[2]) + (px(col_l_q[1]) <<< 1) + px(col_l_q[0]));
        gy_d = (px(col_l_q[0]) + (px(col_c_q[0]) <<< 1) + px(col_r_q[0]))
             - (px(col_l_q[2]) + (px(col_c_q[2]) <<< 1) + px(col_r_q[2]));
        border_d = (hc_c_q == 11'd0) || (hc_c_q == H_LAST)
                || (vc_c_q == 10'd0) || (vc_c_q == V_LAST);
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            gx_q     <= '0;
            gy_q     <= '0;
            border_q <= 1'b0;
            hc1_q    <= '0;
            vc1_q    <= '0;
            v1_q     <= 1'b0;
        end else begin
            v1_q <= v0_q;
            if (v0_q) begin
                gx_q     <= gx_d;
                gy_q     <= gy_d;
                border_q <= border_d;
                hc1_q    <= hc_c_q;
                vc1_q    <= vc_c_q;
            end
        end
    end

    logic [10:0] abs_x, abs_y, sum_d, mag_d;
    logic [6:0]  pix_d;
    logic        edge_d;

    always_comb begin
        abs_x = gx_q[10] ? $unsigned(-gx_q) : $unsigned(gx_q);
        abs_y = gy_q[10] ? $unsigned(-gy_q) : $unsigned(gy_q);
        sum_d = abs_x + abs_y;
        mag_d = sum_d >> MAG_SHIFT;
        pix_d = (mag_d > 11'd127) ? 7'd127 : mag_d[6:0];
        if (border_q) pix_d = '0;
        edge_d = ({1'b0, pix_d} >= THR);
    end

    logic [6:0]  pix_q;
    logic        edge_q;
    logic [10:0] hco_q;
    logic [9:0]  vco_q;
    logic        vo_q;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            pix_q  <= '0;
            edge_q <= 1'b0;
            hco_q  <= '0;
            vco_q  <= '0;
            vo_q   <= 1'b0;
        end else begin
            vo_q <= v1_q;
            if (v1_q) begin
                pix_q  <= pix_d;
                edge_q <= edge_d;
                hco_q  <= hc1_q;
                vco_q  <= vc1_q;
            end
        end
    end

    assign bus.pixel_out      = pix_q;
    assign bus.edge_out       = edge_q;
    assign bus.hcount_out     = hco_q;
    assign bus.vcount_out     = vco_q;
    assign bus.data_valid_out = vo_q;

endmodule

// File: tb/tb_sobel_edge_filter.sv
// tb/tb_sobel_edge_filter.sv - directed self-checking bench for sobel_edge_filter
module tb_sobel_edge_filter;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   tests_run = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sobel_edge_filter_if bus0();
    sobel_edge_filter_if bus1();

    sobel_edge_filter #(.H_ACTIVE(320), .V_ACTIVE(240), .MAG_SHIFT(3), .THRESHOLD(32)) dut0 (
        .clk_in(clk), .rst_in(rst_n), .bus(bus0)
    );
    sobel_edge_filter #(.H_ACTIVE(320), .V_ACTIVE(240), .MAG_SHIFT(2), .THRESHOLD(32)) dut1 (
        .clk_in(clk), .rst_in(rst_n), .bus(bus1)
    );

    assign bus1.line_buffer_in = bus0.line_buffer_in;
    assign bus1.hcount_in      = bus0.hcount_in;
    assign bus1.vcount_in      = bus0.vcount_in;
    assign bus1.data_valid_in  = bus0.data_valid_in;

    typedef struct {
        int hc;
        int vc;
        int pix;
        int edg;
        int cyc;
    } out_t;

    out_t q0[$];
    out_t q1[$];
    out_t e0, e1;

    always @(negedge clk) begin
        if (bus0.data_valid_out) begin
            e0.hc = int'(bus0.hcount_out); e0.vc = int'(bus0.vcount_out);
            e0.pix = int'(bus0.pixel_out); e0.edg = int'(bus0.edge_out); e0.cyc = cyc;
            q0.push_back(e0);
        end
        if (bus1.data_valid_out) begin
            e1.hc = int'(bus1.hcount_out); e1.vc = int'(bus1.vcount_out);
            e1.pix = int'(bus1.pixel_out); e1.edg = int'(bus1.edge_out); e1.cyc = cyc;
            q1.push_back(e1);
        end
    end

    // mode 0 flat 50, mode 1 vertical step at column 160, mode 2 pseudo-random, mode 3 saturation window
    function automatic int img(input int mode, input int r, input int c);
        if (mode == 1) return (c >= 160) ? 100 : 0;
        if (mode == 2) begin
            if (r < 0 || r > 239) return 0;
            return (r * 131 + c * 71 + ((r * c) % 29) * 5) % 128;
        end
        return 50;
    endfunction

    function automatic logic [2:0][6:0] col_of(input int mode, input int r, input int c);
        logic [2:0][6:0] v;
        if (mode == 3) begin
            v[2] = (c >= 11) ? 7'd127 : 7'd0;
            v[1] = (c >= 10) ? 7'd127 : 7'd0;
            v[0] = 7'd127;
        end else begin
            v[2] = 7'(img(mode, r - 1, c));
            v[1] = 7'(img(mode, r, c));
            v[0] = 7'(img(mode, r + 1, c));
        end
        return v;
    endfunction

    function automatic int exp_pix(input int mode, input int r, input int c, input int sh);
        int gx, gy, s, w;
        if (c == 0 || c == 319 || r == 0 || r == 239) return 0;
        gx = 0;
        gy = 0;
        for (int k = 0; k < 3; k++) begin
            w = (k == 1) ? 2 : 1;
            gx += w * (img(mode, r - 1 + k, c + 1) - img(mode, r - 1 + k, c - 1));
            gy += w * (img(mode, r + 1, c - 1 + k) - img(mode, r - 1, c - 1 + k));
        end
        s = ((gx < 0) ? -gx : gx) + ((gy < 0) ? -gy : gy);
        s = s >> sh;
        return (s > 127) ? 127 : s;
    endfunction

    task automatic drive(input logic [2:0][6:0] col, input int h, input int v);
        @(posedge clk); #1;
        bus0.line_buffer_in = col;
        bus0.hcount_in      = 11'(h);
        bus0.vcount_in      = 10'(v);
        bus0.data_valid_in  = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            bus0.data_valid_in = 1'b0;
        end
    endtask

    task automatic send_row(input int mode, input int r);
        for (int c = 0; c < 320; c++) drive(col_of(mode, r, c), c, r);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (bus0.data_valid_out !== 1'b0 || bus0.pixel_out !== 7'd0 || bus0.edge_out !== 1'b0
            || bus0.hcount_out !== 11'd0 || bus0.vcount_out !== 10'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got v=%b p=%0d e=%b h=%0d vc=%0d, want all 0",
                     bus0.data_valid_out, bus0.pixel_out, bus0.edge_out, bus0.hcount_out, bus0.vcount_out);
        end
        rst_n = 1'b1;
        q0.delete();
        drive(col_of(2, 10, 5), 5, 10);
        for (int c = 6; c < 12; c++) drive(col_of(2, 10, c), c, 10);
        idle(8);
        tests_run++;
        if (q0.size() != 0) begin
            tests_failed++;
            $display("FAIL idle_ignores_nonzero: got %0d outputs, want 0", q0.size());
        end
    endtask

    task automatic test_flat;
        q0.delete();
        send_row(0, 1);
        idle(6);
        send_row(0, 120);
        idle(6);
        tests_run++;
        if (q0.size() != 640) begin
            tests_failed++;
            $display("FAIL flat_count: got %0d, want 640", q0.size());
        end
        for (int i = 0; i < q0.size() && i < 640; i++) begin
            tests_run++;
            if (q0[i].hc !== i % 320 || q0[i].vc !== ((i < 320) ? 1 : 120) || q0[i].pix !== 0 || q0[i].edg !== 0) begin
                tests_failed++;
                $display("FAIL flat[%0d]: got hc=%0d vc=%0d p=%0d e=%0d, want hc=%0d vc=%0d p=0 e=0",
                         i, q0[i].hc, q0[i].vc, q0[i].pix, q0[i].edg, i % 320, (i < 320) ? 1 : 120);
            end
        end
    endtask

    task automatic test_vertical_step;
        int want_p, want_e;
        q0.delete();
        send_row(1, 120);
        idle(6);
        tests_run++;
        if (q0.size() != 320) begin
            tests_failed++;
            $display("FAIL step_count: got %0d, want 320", q0.size());
        end
        for (int i = 0; i < q0.size() && i < 320; i++) begin
            want_p = (i == 159 || i == 160) ? 50 : 0;
            want_e = (i == 159 || i == 160) ? 1 : 0;
            tests_run++;
            if (q0[i].hc !== i || q0[i].pix !== want_p || q0[i].edg !== want_e) begin
                tests_failed++;
                $display("FAIL step[%0d]: got hc=%0d p=%0d e=%0d, want hc=%0d p=%0d e=%0d",
                         i, q0[i].hc, q0[i].pix, q0[i].edg, i, want_p, want_e);
            end
        end
    endtask

    task automatic test_saturation;
        q0.delete();
        q1.delete();
        send_row(3, 5);
        idle(6);
        tests_run++;
        if (q1.size() != 320 || q0.size() != 320) begin
            tests_failed++;
            $display("FAIL sat_count: got %0d/%0d, want 320/320", q0.size(), q1.size());
        end
        if (q1.size() > 10 && q0.size() > 10) begin
            tests_run++;
            if (q1[10].hc !== 10 || q1[10].pix !== 127 || q1[10].edg !== 1) begin
                tests_failed++;
                $display("FAIL sat_shift2: got hc=%0d p=%0d e=%0d, want hc=10 p=127 e=1",
                         q1[10].hc, q1[10].pix, q1[10].edg);
            end
            tests_run++;
            if (q0[10].hc !== 10 || q0[10].pix !== 95 || q0[10].edg !== 1) begin
                tests_failed++;
                $display("FAIL sat_shift3: got hc=%0d p=%0d e=%0d, want hc=10 p=95 e=1",
                         q0[10].hc, q0[10].pix, q0[10].edg);
            end
        end
    endtask

    task automatic test_borders;
        int rows[3] = '{0, 100, 239};
        int r, w0, w1;
        foreach (rows[k]) begin
            r = rows[k];
            q0.delete();
            q1.delete();
            send_row(2, r);
            idle(6);
            tests_run++;
            if (q0.size() != 320 || q1.size() != 320) begin
                tests_failed++;
                $display("FAIL border_count r%0d: got %0d/%0d, want 320/320", r, q0.size(), q1.size());
            end
            for (int i = 0; i < q0.size() && i < q1.size() && i < 320; i++) begin
                w0 = exp_pix(2, r, i, 3);
                w1 = exp_pix(2, r, i, 2);
                tests_run++;
                if (q0[i].hc !== i || q0[i].vc !== r || q0[i].pix !== w0 || q0[i].edg !== int'(w0 >= 32)
                    || q1[i].pix !== w1) begin
                    tests_failed++;
                    $display("FAIL border r%0d c%0d: got hc=%0d vc=%0d p=%0d e=%0d p2=%0d, want hc=%0d vc=%0d p=%0d e=%0d p2=%0d",
                             r, i, q0[i].hc, q0[i].vc, q0[i].pix, q0[i].edg, q1[i].pix,
                             i, r, w0, int'(w0 >= 32), w1);
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        int r, w;
        q0.delete();
        send_row(2, 100);
        send_row(2, 101);
        idle(6);
        tests_run++;
        if (q0.size() != 640) begin
            tests_failed++;
            $display("FAIL b2b_count: got %0d, want 640", q0.size());
        end
        for (int i = 0; i < q0.size() && i < 640; i++) begin
            r = (i < 320) ? 100 : 101;
            w = exp_pix(2, r, i % 320, 3);
            tests_run++;
            if (q0[i].hc !== i % 320 || q0[i].vc !== r || q0[i].pix !== w) begin
                tests_failed++;
                $display("FAIL b2b[%0d]: got hc=%0d vc=%0d p=%0d, want hc=%0d vc=%0d p=%0d",
                         i, q0[i].hc, q0[i].vc, q0[i].pix, i % 320, r, w);
            end
        end
    endtask

    task automatic test_timing;
        int t_first = -1;
        int t318 = -1;
        int t319 = -1;
        logic post_valid = 1'b1;
        for (int t = 0; t < 340; t++) begin
            @(posedge clk); #1;
            if (t < 320) begin
                bus0.line_buffer_in = col_of(0, 50, t);
                bus0.hcount_in      = 11'(t);
                bus0.vcount_in      = 10'd50;
                bus0.data_valid_in  = 1'b1;
            end else begin
                bus0.data_valid_in  = 1'b0;
            end
            @(negedge clk);
            if (t319 >= 0 && t == t319 + 1) post_valid = bus0.data_valid_out;
            if (bus0.data_valid_out) begin
                if (t_first < 0) t_first = t;
                if (bus0.hcount_out == 11'd318) t318 = t;
                if (bus0.hcount_out == 11'd319) t319 = t;
            end
        end
        tests_run++;
        if (t_first !== 4) begin
            tests_failed++;
            $display("FAIL first_latency: got first valid at %0d, want 4 (3 clk after hcount 1 beat)", t_first);
        end
        tests_run++;
        if (t318 !== 322 || t319 !== 323) begin
            tests_failed++;
            $display("FAIL flush_timing: got col318@%0d col319@%0d, want 322/323", t318, t319);
        end
        tests_run++;
        if (post_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL valid_drop: got valid=%b after col 319, want 0", post_valid);
        end
    endtask

    task automatic test_flush_violation;
        q0.delete();
        send_row(0, 60);
        for (int c = 5; c < 11; c++) drive(col_of(0, 60, c), c, 60);
        idle(8);
        tests_run++;
        if (q0.size() != 320) begin
            tests_failed++;
            $display("FAIL flush_violation_count: got %0d, want 320", q0.size());
        end
        if (q0.size() > 0) begin
            tests_run++;
            if (q0[q0.size() - 1].hc !== 319) begin
                tests_failed++;
                $display("FAIL flush_violation_last: got hc=%0d, want 319", q0[q0.size() - 1].hc);
            end
        end
    endtask

    task automatic test_mid_reset;
        int w;
        for (int c = 0; c < 100; c++) drive(col_of(2, 70, c), c, 70);
        @(posedge clk); #1;
        bus0.line_buffer_in = col_of(2, 70, 100);
        bus0.hcount_in      = 11'd100;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (bus0.data_valid_out !== 1'b0 || bus0.pixel_out !== 7'd0 || bus0.hcount_out !== 11'd0) begin
            tests_failed++;
            $display("FAIL reset_immediate: got v=%b p=%0d h=%0d, want 0/0/0",
                     bus0.data_valid_out, bus0.pixel_out, bus0.hcount_out);
        end
        @(posedge clk); #1;
        bus0.data_valid_in = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        q0.delete();
        for (int c = 101; c < 320; c++) drive(col_of(2, 70, c), c, 70);
        idle(8);
        tests_run++;
        if (q0.size() != 0) begin
            tests_failed++;
            $display("FAIL reset_silence: got %0d outputs, want 0", q0.size());
        end
        send_row(2, 71);
        idle(6);
        tests_run++;
        if (q0.size() != 320) begin
            tests_failed++;
            $display("FAIL reset_resume_count: got %0d, want 320", q0.size());
        end
        for (int i = 0; i < q0.size() && i < 320; i++) begin
            w = exp_pix(2, 71, i, 3);
            tests_run++;
            if (q0[i].hc !== i || q0[i].vc !== 71 || q0[i].pix !== w) begin
                tests_failed++;
                $display("FAIL reset_resume[%0d]: got hc=%0d vc=%0d p=%0d, want hc=%0d vc=71 p=%0d",
                         i, q0[i].hc, q0[i].vc, q0[i].pix, i, w);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus0.line_buffer_in = '0;
        bus0.hcount_in      = '0;
        bus0.vcount_in      = '0;
        bus0.data_valid_in  = 1'b0;
        test_reset();
        test_flat();
        test_vertical_step();
        test_saturation();
        test_borders();
        test_back_to_back();
        test_timing();
        test_flush_violation();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
